// File: rtl/memctl_pkg.sv
// Shared types and defaults for the memory controller.
// Holds the controller state encoding and default bus widths.
// Imported by memory_control and its testbench.
package memctl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } memctl_state_t;

endpackage

// File: rtl/memory_control.sv
// Arbitrates datapath data and instruction requests onto one shared RAM port (data first).
// Latency: ram_ready in cycle N gives a one-cycle hit in N+1; minimum request-to-hit is 3 cycles.
// Backpressure: RAM stalls via ram_ready; requests are sampled only in IDLE. Optional MEMCTL_PERF_EN adds hit counters.
module memory_control
  import memctl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEMCTL_PERF_EN
  ,parameter int CNT_W = 32
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iRen,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dRen,
  input  logic              dWen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iHit,
  output logic              dHit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
`ifdef MEMCTL_PERF_EN
  ,output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0]  dcount
`endif
);

  memctl_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;
  logic [DATA_W-1:0] iload_q;
  logic [DATA_W-1:0] dload_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture in IDLE (dWen beats dRen) and load-data capture on RAM completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dRen || dWen) begin
            addr_q <= daddr;
            data_q <= dstore;
            wr_q   <= dWen;
          end else if (iRen) begin
            addr_q <= iaddr;
            wr_q   <= 1'b0;
          end
        end
        DACC: if (ram_ready && !wr_q) dload_q <= ramload;
        IACC: if (ram_ready) iload_q <= ramload;
        default: ;
      endcase
    end
  end

  // Next-state and RAM/hit decode; hits come from state only, never from ram_ready.
  always_comb begin
    state_d  = state_q;
    iHit     = 1'b0;
    dHit     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      IDLE: begin
        if (dRen || dWen) state_d = DACC;
        else if (iRen)    state_d = IACC;
      end
      DACC: begin
        ramaddr  = addr_q;
        ramREN   = !wr_q;
        ramWEN   = wr_q;
        ramstore = wr_q ? data_q : '0;
        if (ram_ready) state_d = DRESP;
      end
      IACC: begin
        ramaddr = addr_q;
        ramREN  = 1'b1;
        if (ram_ready) state_d = IRESP;
      end
      // One-cycle gap lets the requester drop its strobe before IDLE samples again.
      DRESP: begin
        dHit    = 1'b1;
        state_d = IDLE;
      end
      IRESP: begin
        iHit    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign iload = iload_q;
  assign dload = dload_q;

`ifdef MEMCTL_PERF_EN
  logic [CNT_W-1:0] icount_q;
  logic [CNT_W-1:0] dcount_q;

  // Count completed instruction fetches (wraps naturally).
  always_ff @(posedge CLK) begin
    if (RST)                 icount_q <= '0;
    else if (state_q == IRESP) icount_q <= icount_q + 1'b1;
  end

  // Count completed data accesses (wraps naturally).
  always_ff @(posedge CLK) begin
    if (RST)                 dcount_q <= '0;
    else if (state_q == DRESP) dcount_q <= dcount_q + 1'b1;
  end

  assign icount = icount_q;
  assign dcount = dcount_q;
`endif

endmodule

// File: doc/memory_control.md
Name: memory_control

Overview:
- Downstream of the request unit.
- Consumes the iRen/dRen/dWen strobes and addresses from the single-cycle datapath and arbitrates them onto one shared RAM port.
- Returns one-cycle iHit/dHit pulses plus load data to the request unit and datapath.
- Data accesses have priority over instruction fetches. RAM latency is variable and is handshaked via ram_ready.

Parameters:
- ADDR_W, 32, width of all addresses.
- DATA_W, 32, width of all data words.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- iRen  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- dRen  in  1  data read request
- dWen  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- iHit  out  1  instruction fetch complete; one-cycle pulse
- dHit  out  1  data access complete; one-cycle pulse
- iload  out  DATA_W  fetched instruction; valid while iHit=1
- dload  out  DATA_W  loaded data; valid while dHit=1
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data; valid when ram_ready=1
- ram_ready  in  1  RAM has completed the current access this cycle

Behaviour:
- Clocking and reset: single clock domain, posedge CLK. Reset is synchronous and active-high: CLK, RST.
- Reset state and output values:
  - FSM goes to IDLE.
  - iHit, dHit, ramREN, ramWEN = 0.
  - ramaddr, ramstore, iload, dload, and the latched op/addr/data = 0.
- FSM states: IDLE, DACC, IACC, DRESP, IRESP.
- IDLE transitions:
  - dRen|dWen → DACC. Latch daddr, dstore, and op. dWen wins if dRen&dWen are both high, so the latched op is a write.
  - Else iRen → IACC. Latch iaddr.
  - Else stay in IDLE.
- DACC:
  - ramaddr = latched address.
  - ramREN = latched read; ramWEN = latched write; ramstore = latched data.
  - Hold until ram_ready=1. On that cycle capture ramload into dload (reads only; writes leave dload unchanged), then go to DRESP.
- IACC: same as DACC but ramREN=1 only. On ram_ready capture ramload into iload, then go to IRESP.
- DRESP/IRESP:
  - dHit (resp. iHit) = 1 for exactly this one cycle; RAM strobes = 0.
  - Next state is unconditionally IDLE.
  - This gap cycle lets the request unit clear its strobe at the edge on which it observes the hit, so the same request is never re-issued.
- Hit outputs are decoded from state, so they carry no combinational path from ram_ready.
- Latency: ram_ready asserted in cycle N → hit in cycle N+1. Minimum request-to-hit latency is 3 cycles: IDLE, ACC with ram_ready=1, RESP.
- Requests are sampled only in IDLE. Changes to addresses, data, or strobes during ACC/RESP are ignored until the next IDLE.
- ram_ready outside DACC/IACC is ignored.
- Both requests pending in IDLE: the data access is served first, then the instruction fetch starts from the following IDLE.
- RST asserted mid-access: strobes drop at the next edge, no hit is produced, and the pending request is discarded. The requester must re-assert.
- At most one RAM transaction is outstanding; there is no buffering.

Optional Feature:
- Macro: MEMCTL_PERF_EN.
- Defined:
  - Adds outputs icount and dcount [CNT_W].
  - Each increments by 1 in every IRESP/DRESP cycle, respectively. Both wrap modulo 2^CNT_W.
  - Both clear on RST.
- Undefined: ports and counter logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package memctl_pkg holds:
  - typedef enum logic [2:0] memctl_state_t with IDLE, DACC, IACC, DRESP, IRESP.
  - Constants ADDR_W_DEF=32, DATA_W_DEF=32.
- Sub-module: none required. The perf counters are two always_ff blocks inside the `ifdef`.

Test Plan:
- Fetch with latency: iRen=1, iaddr=0x0000_0040; ram_ready high on the 3rd ACC cycle with ramload=0x2008_0005 → ramREN=1 and ramaddr=0x40 for 3 cycles, then iHit=1 for 1 cycle with iload=0x2008_0005.
- Priority: iRen=1 and dRen=1 together, daddr=0x100, ram_ready=1 immediately → DACC first, dHit on cycle 3; iHit on cycle 6 with ramaddr=iaddr.
- Store: dWen=1, daddr=0x200, dstore=0xDEAD_BEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF until ram_ready; dHit one cycle; dload unchanged.
- Conflict: dRen=dWen=1 → only ramWEN asserts.
- Stable request: dRen held high through the hit cycle and dropped the following cycle → exactly one RAM transaction.
- Reset mid-access: RST=1 during IACC → next cycle all outputs 0, state IDLE, no iHit.
- With MEMCTL_PERF_EN: 3 fetches and 2 loads → icount=3, dcount=2. Preload icount=2^CNT_W−1, one fetch → wraps to 0.
